// File: rtl/toast_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// The register window sits on the core data-memory port. Read data and the
// hit flag are registered, so they line up with the synchronous data RAM.
module toast_uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  wr_byte_en_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rd_data_o,
    output logic        hit_o,
    output logic        uart_tx_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    localparam logic [1:0] OffTxData = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffDiv    = 2'd2;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Register window decode
    logic       win_hit;
    logic [1:0] offset;
    logic       wr_en;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       ovf_set;
    logic       ovf_clr;
    logic       fifo_full;
    logic       fifo_empty;

    // FIFO state
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] count_q;

    // Control registers and read port
    logic        ovf_q;
    logic [15:0] div_q;
    logic [15:0] eff_period;
    logic [31:0] status_word;
    logic [31:0] rd_data_d;
    logic [31:0] rd_data_q;
    logic        hit_q;

    // TX engine
    state_e      state_q;
    state_e      state_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [15:0] period_q;
    logic [15:0] period_d;
    logic [15:0] baud_cnt_q;
    logic [15:0] baud_cnt_d;
    logic [2:0]  bit_idx_q;
    logic [2:0]  bit_idx_d;
    logic        tx_q;
    logic        tx_d;
    logic        bit_done;
    logic        busy;

    // Bits of the bus that this block never looks at
    logic unused_bus;
    assign unused_bus = ^{addr_i[1:0], wr_data_i[31:16], wr_byte_en_i[3:2]};

    assign win_hit  = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign offset   = addr_i[3:2];
    assign wr_en    = |wr_byte_en_i;

    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);

    // Fullness is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign push_req = win_hit && wr_en && (offset == OffTxData) && wr_byte_en_i[0];
    assign push     = push_req && !fifo_full;
    assign ovf_set  = push_req && fifo_full;
    assign ovf_clr  = win_hit && wr_en && (offset == OffStatus) && wr_byte_en_i[0]
                      && wr_data_i[3];

    assign bit_done   = (baud_cnt_q == '0);
    assign busy       = (state_q != StIdle);
    assign eff_period = (div_q < 16'd2) ? 16'd2 : div_q;

    assign status_word = {16'b0, 8'(count_q), 4'b0, ovf_q, busy, fifo_empty, fifo_full};

    // FIFO storage, no reset needed since entries are only read when counted
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data_i[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and divisor register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            div_q <= DIV_RESET;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (win_hit && (offset == OffDiv)) begin
                if (wr_byte_en_i[0]) begin
                    div_q[7:0] <= wr_data_i[7:0];
                end
                if (wr_byte_en_i[1]) begin
                    div_q[15:8] <= wr_data_i[15:8];
                end
            end
        end
    end

    // Read mux from pre-write register state
    always_comb begin
        rd_data_d = '0;
        if (win_hit) begin
            unique case (offset)
                OffStatus: rd_data_d = status_word;
                OffDiv:    rd_data_d = {16'b0, div_q};
                default:   rd_data_d = '0;
            endcase
        end
    end

    // Registered read port, one cycle behind the address
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            hit_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            hit_q     <= win_hit;
        end
    end

    // TX FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // TX FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done && (bit_idx_q == 3'd7)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    state_d = fifo_empty ? StIdle : StStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // TX FSM outputs: pop strobe and next values of the serialiser datapath
    always_comb begin
        pop        = 1'b0;
        shift_d    = shift_q;
        period_d   = period_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            StStart: begin
                if (bit_done) begin
                    baud_cnt_d = period_q - 16'd1;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StData: begin
                if (bit_done) begin
                    baud_cnt_d = period_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    tx_d = 1'b1;
                    // Chain straight into the next frame with no idle gap
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: tx_d = 1'b1;
        endcase
        // Frame load: the period is latched here so DIV writes only hit later frames
        if (pop) begin
            shift_d    = mem_q[rptr_q];
            period_d   = eff_period;
            baud_cnt_d = eff_period - 16'd1;
            bit_idx_d  = 3'd0;
            tx_d       = 1'b0;
        end
    end

    // Serialiser datapath registers; the line is driven straight from tx_q
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q    <= '0;
            period_q   <= 16'd2;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            shift_q    <= shift_d;
            period_q   <= period_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign hit_o     = hit_q;
    assign uart_tx_o = tx_q;

endmodule

// File: doc/toast_uart_tx_mmio.md
# toast_uart_tx_mmio

Memory-mapped UART transmitter on the core's data-memory port, downstream of `toast_top`. It decodes a 16-byte address window from the core's data-memory address, byte enables and write data, and buffers written bytes in a FIFO. A TX state machine serialises the bytes as 8N1 frames. Read data and a window-hit flag are returned one cycle after the address, matching the synchronous data RAM, so an external mux can select between the RAM and this block.

## Interface
- `BASE_ADDR`, 32'h8000_0000: window base; bits [3:0] must be 0.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, range 2..128.
- `DIV_RESET`, 16'd868: reset bit-period divisor (100 MHz / 115200).
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `addr_i`  in  32  byte address; connects to DMEM_addr_o.
- `wr_byte_en_i`  in  4  write byte enables; connects to DMEM_wr_byte_en_o; any bit set means a write.
- `wr_data_i`  in  32  write data; connects to DMEM_wr_data_o.
- `rd_data_o`  out  32  registered read data.
- `hit_o`  out  1  registered flag: the previous cycle's address was in the window.
- `uart_tx_o`  out  1  serial line; idle high.

## Operation
- Window hit: `addr_i[31:4] == BASE_ADDR[31:4]`. Offset is `addr_i[3:2]`. Writes outside the window are ignored.
- Offset 0x0, TXDATA (write-only, reads 0): a write with `wr_byte_en_i[0]` pushes `wr_data_i[7:0]`.
  - Push while FIFO full: byte dropped, sticky `ovf` set.
  - Fullness is evaluated before any same-cycle pop, so a push into a full FIFO is dropped even if a pop happens that cycle.
- Offset 0x4, STATUS (read):
  - [0] full; [1] empty; [2] busy (state != IDLE); [3] ovf; [15:8] FIFO count; other bits 0.
  - Write with `wr_byte_en_i[0]` and `wr_data_i[3]`=1 clears `ovf`.
  - A same-cycle overflow wins over the clear.
- Offset 0x8, DIV (R/W, bits [15:0]): byte enables [1:0] update the corresponding bytes; upper bits read 0.
  - Effective period = max(DIV, 2) clock cycles.
  - The period is latched at the start of each frame; a mid-frame write affects the next frame only.
- Offset 0xC: reads 0, writes ignored.
- Reads have no side effects. `rd_data_o` is 0 when the address missed the window.
- FIFO: circular read/write pointers plus a count; both pointers wrap at `FIFO_DEPTH`. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- TX FSM states:
  - IDLE: line high. When FIFO non-empty: pop, load shift register, latch period, go to START.
  - START: line low for one period, then DATA.
  - DATA: 8 bits LSB first, one period each, counted by a 3-bit bit counter.
  - STOP: line high for one period. At its last cycle: if FIFO non-empty, pop and go to START (no idle gap); otherwise go to IDLE.
- The bit-period counter reloads at every bit boundary. `uart_tx_o` is driven from a register; no combinational path from the inputs.

## Timing
- Reset values: `uart_tx_o`=1, `rd_data_o`=0, `hit_o`=0, FSM IDLE, FIFO empty with pointers 0, `ovf`=0, DIV=`DIV_RESET`.
- Reset asserted mid-frame aborts the frame: line high from the cycle after the reset edge; buffered bytes are discarded.
- Read latency: address presented in cycle N gives `rd_data_o`/`hit_o` in cycle N+1. The value reflects register state before any cycle-N write takes effect.
- Write in cycle N: FIFO count and STATUS update from cycle N+1.
- Push in cycle N while IDLE: pop at the end of cycle N+1; `uart_tx_o` goes low in cycle N+2.
- Frame = exactly 10 × period cycles. Back-to-back frames give continuous 10 × period spacing.
- busy drops in the cycle after the last STOP cycle when the FIFO is empty.

## Test plan
- Reset, then read STATUS: `rd_data_o`=0x0000_0002 one cycle later, `hit_o`=1, `uart_tx_o`=1.
- DIV=4; write 0xA5 to TXDATA in cycle N: line low in cycles N+2..N+5, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, high stop for 4 cycles; busy=0 afterwards.
- DIV=2; push 8 bytes back-to-back, then a 9th while 8 are queued: ovf=1, count=7 or 8 per the pop timing. Frames are contiguous (160 cycles, no idle gap); the 9th byte is never sent. Writing STATUS 0x8 clears ovf.
- Write DIV=0 and DIV=1: both produce 2-cycle bits. Write DIV mid-frame: the current frame keeps the old period, the next frame uses the new one.
- Address `BASE_ADDR`+0x10 and 0x0000_0000: `hit_o`=0, `rd_data_o`=0, no FIFO push. Write with `wr_byte_en_i`=4'b0010 to TXDATA: no push.
- Assert `rst_i` in the 3rd data bit of a frame with 3 bytes queued: line high from the next cycle, STATUS=0x2, no further frames.
